// File: rtl/catch_pkg.sv
// Shared types and constants for the catch game engine: direction bits,
// LFSR tap masks, counter limit and the grid position struct.
package catch_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam logic [3:0] CNT_MAX = 4'd15;

    // Widest legal coordinate; narrower grids keep the upper bits at zero.
    localparam int POS_W = 3;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

    // Feedback taps keyed by COORD_W: the top two register bits.
    function automatic logic [7:0] lfsr_taps(input int coord_w);
        logic [7:0] taps;
        case (coord_w)
            3:       taps = 8'b0011_0000;
            default: taps = 8'b0000_1100;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/catch_lfsr.sv
// Fibonacci LFSR, seed 1, shifting left with feedback into bit 0.
// Latency: next value is combinational, state updates one edge later when en=1; no backpressure.
module catch_lfsr
    import catch_pkg::*;
#(
    parameter int         W    = 4,
    parameter logic [W-1:0] TAPS = W'(lfsr_taps(W / 2))
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] lfsr_q,
    output logic [W-1:0] lfsr_d
);

    always_comb begin
        lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= W'(1);
        end else if (en) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/catch.sv
// Catch-the-target game engine; CATCH_WRAP_EN makes the grid toroidal, otherwise moves clamp at edges.
// Latency: a move is reflected in durum/yakalama_sayisi one edge later; no backpressure, input sampled every clock.
module catch
    import catch_pkg::*;
#(
    parameter int COORD_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] yon,
    output logic       durum,
    output logic [3:0] yakalama_sayisi
);

    localparam int LW = 2 * COORD_W;
    localparam logic [POS_W-1:0] COORD_MAX = POS_W'((1 << COORD_W) - 1);
    localparam logic [POS_W-1:0] COORD_MID = POS_W'(1 << (COORD_W - 1));
    localparam logic [POS_W-1:0] ONE       = POS_W'(1);

    pos_t          player_q, player_d;
    pos_t          target_q, target_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          durum_q, durum_d;
    logic          catch_hit;
    logic [LW-1:0] lfsr_nxt;

    // Opposing requests cancel; only a lone dec or inc moves the axis.
    function automatic logic [POS_W-1:0] step_axis(input logic [POS_W-1:0] c,
                                                    input logic dec,
                                                    input logic inc);
        logic [POS_W-1:0] r;
        r = c;
        if (dec && !inc) begin
`ifdef CATCH_WRAP_EN
            r = (c - ONE) & COORD_MAX;
`else
            if (c != '0) r = c - ONE;
`endif
        end else if (inc && !dec) begin
`ifdef CATCH_WRAP_EN
            r = (c + ONE) & COORD_MAX;
`else
            if (c != COORD_MAX) r = c + ONE;
`endif
        end
        return r;
    endfunction

    catch_lfsr #(
        .W (LW)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en     (1'b1),
        .lfsr_q (),
        .lfsr_d (lfsr_nxt)
    );

    always_comb begin
        player_d   = player_q;
        player_d.x = step_axis(player_q.x, yon[DIR_LEFT], yon[DIR_RIGHT]);
        player_d.y = step_axis(player_q.y, yon[DIR_UP], yon[DIR_DOWN]);

        catch_hit = (player_d == target_q);
        target_d  = target_q;
        cnt_d     = cnt_q;
        durum_d   = catch_hit;
        if (catch_hit) begin
            cnt_d      = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
            // Relocation uses the value the LFSR takes on this same edge.
            target_d.x = POS_W'(lfsr_nxt[LW-1:COORD_W]);
            target_d.y = POS_W'(lfsr_nxt[COORD_W-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            player_q <= '0;
            target_q <= '{x: COORD_MID, y: COORD_MID};
            cnt_q    <= '0;
            durum_q  <= 1'b0;
        end else begin
            player_q <= player_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            durum_q  <= durum_d;
        end
    end

    assign durum           = durum_q;
    assign yakalama_sayisi = cnt_q;

endmodule

// File: tb/tb_catch.sv
// Directed bench for catch: vector table for reset/diagonal/edge/opposing cases,
// plus steered sequences for counter saturation and mid-game async reset.
module tb_catch;

    localparam int CW = 2;
    localparam int N  = 1 << CW;
    localparam int LW = 2 * CW;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] yon = 4'b0000;
    logic       durum;
    logic [3:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    catch #(.COORD_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .yon             (yon),
        .durum           (durum),
        .yakalama_sayisi (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst_before;
        logic [3:0] yon;
        logic       exp_durum;
        logic [3:0] exp_cnt;
        string      name;
    } vec_t;

    vec_t vecs[$];

    // Reference model of the game, used for the steered sequences.
    int            m_px, m_py, m_tx, m_ty, m_cnt;
    logic          m_durum;
    logic [LW-1:0] m_lfsr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input logic [3:0] y, input logic d,
                       input logic [3:0] c, input string nm);
        vec_t v;
        v.rst_before = r;
        v.yon        = y;
        v.exp_durum  = d;
        v.exp_cnt    = c;
        v.name       = nm;
        vecs.push_back(v);
    endtask

    function automatic int mv(input int c, input bit dec, input bit inc);
        if (dec && !inc) begin
`ifdef CATCH_WRAP_EN
            return (c == 0) ? N - 1 : c - 1;
`else
            return (c == 0) ? 0 : c - 1;
`endif
        end
        if (inc && !dec) begin
`ifdef CATCH_WRAP_EN
            return (c == N - 1) ? 0 : c + 1;
`else
            return (c == N - 1) ? N - 1 : c + 1;
`endif
        end
        return c;
    endfunction

    task automatic model_reset();
        m_px = 0; m_py = 0;
        m_tx = N / 2; m_ty = N / 2;
        m_lfsr = 1; m_cnt = 0; m_durum = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] y);
        int nx, ny;
        logic [LW-1:0] ln;
        nx = mv(m_px, y[1], y[0]);
        ny = mv(m_py, y[3], y[2]);
        ln = {m_lfsr[LW-2:0], m_lfsr[LW-1] ^ m_lfsr[LW-2]};
        if (nx == m_tx && ny == m_ty) begin
            m_durum = 1'b1;
            m_cnt   = (m_cnt == 15) ? 15 : m_cnt + 1;
            m_tx    = int'(ln[LW-1:CW]);
            m_ty    = int'(ln[CW-1:0]);
        end else begin
            m_durum = 1'b0;
        end
        m_px = nx; m_py = ny; m_lfsr = ln;
    endtask

    function automatic logic [3:0] steer();
        return {m_ty < m_py, m_ty > m_py, m_tx < m_px, m_tx > m_px};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        yon = 4'b0000;
        @(posedge clk);
        #1;
        check("reset_durum", int'(durum), 0);
        check("reset_cnt", int'(cnt), 0);
        rst = 1'b1;
        model_reset();
    endtask

    // One steered move; the DUT is compared with the model after the edge.
    task automatic steered_step(input string tag);
        logic [3:0] y;
        y = steer();
        model_step(y);
        yon = y;
        @(posedge clk);
        #1;
        check({tag, "_durum"}, int'(durum), int'(m_durum));
        check({tag, "_cnt"}, int'(cnt), m_cnt);
    endtask

    initial begin
        int catches;

        for (int i = 0; i < 5; i++) add(i == 0, 4'b0000, 1'b0, 4'd0, "idle");

        add(1'b1, 4'b0101, 1'b0, 4'd0, "diag");
        add(1'b0, 4'b0101, 1'b1, 4'd1, "diag");
        add(1'b0, 4'b0000, 1'b0, 4'd1, "diag");

`ifdef CATCH_WRAP_EN
        add(1'b1, 4'b1010, 1'b0, 4'd0, "edge");
        add(1'b0, 4'b1010, 1'b1, 4'd1, "edge");
        add(1'b0, 4'b1010, 1'b0, 4'd1, "edge");
`else
        for (int i = 0; i < 3; i++) add(i == 0, 4'b1010, 1'b0, 4'd0, "edge");
`endif

        for (int i = 0; i < 10; i++) add(i == 0, 4'b1111, 1'b0, 4'd0, "oppose");

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) do_reset();
            yon = vecs[i].yon;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]_durum", vecs[i].name, i), int'(durum), int'(vecs[i].exp_durum));
            check($sformatf("%s[%0d]_cnt", vecs[i].name, i), int'(cnt), int'(vecs[i].exp_cnt));
        end

        // Saturation: chase the target for 17 catches.
        do_reset();
        catches = 0;
        for (int c = 0; c < 600 && catches < 17; c++) begin
            steered_step("sat");
            if (durum) begin
                catches++;
                if (catches >= 15) check($sformatf("sat_cnt_after_%0d", catches), int'(cnt), 15);
            end
        end
        check("sat_catches", catches, 17);
        check("sat_final_cnt", int'(cnt), 15);

        // Async reset mid-game, asserted between edges.
        do_reset();
        for (int c = 0; c < 300 && m_cnt < 3; c++) steered_step("mid");
        check("mid_pre_cnt", int'(cnt), 3);
        check("mid_pre_durum", int'(durum), 1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_async_cnt", int'(cnt), 0);
        check("mid_async_durum", int'(durum), 0);
        rst = 1'b1;
        yon = 4'b0101;
        @(posedge clk);
        #1;
        check("mid_after_1_durum", int'(durum), 0);
        check("mid_after_1_cnt", int'(cnt), 0);
        @(posedge clk);
        #1;
        check("mid_after_2_durum", int'(durum), 1);
        check("mid_after_2_cnt", int'(cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/catch.md
Name: catch

Overview:
- Single-player "catch the target" game engine on a square grid of 2^COORD_W × 2^COORD_W cells.
- A player token is steered each clock by a 4-bit direction input. A catch occurs when the player's next position equals the target cell.
- On each catch the target jumps to a pseudo-random cell and a saturating 4-bit catch counter increments.
- Sits behind the input-debounce/decoder logic; drives the score display and the catch indicator.

Parameters:
- COORD_W, 2, coordinate width per axis. Legal values are 2 (4×4 grid, 4-bit LFSR) and 3 (8×8 grid, 6-bit LFSR).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- yon  input  4  direction request: bit3 = up (y−1), bit2 = down (y+1), bit1 = left (x−1), bit0 = right (x+1).
- durum  output  1  catch flag; registered; 1 for exactly the cycle after a catch edge.
- yakalama_sayisi  output  4  catch count, saturating at 15.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low; it is the only reset.
- While rst=0:
  - player = (0,0)
  - target = (2^(COORD_W−1), 2^(COORD_W−1)), i.e. (2,2) by default
  - lfsr = 1
  - yakalama_sayisi = 0
  - durum = 0
  - Reset mid-game clears everything immediately, with no clock needed.
- Internal state: player x,y (COORD_W bits each), target x,y, lfsr (2·COORD_W bits), count, durum.
- Movement (combinational player_next from player and yon):
  - Vertical: up-only gives y−1; down-only gives y+1; both or neither leave y unchanged.
  - Horizontal: left/right follow the same rule on x.
  - Both axes may change in the same cycle (diagonal move).
  - Edges: clamp at 0 and 2^COORD_W−1 (a move past the edge is ignored on that axis). WRAP_EN changes this; see Optional Feature.
- LFSR: free-running; advances every clock out of reset.
  - 4-bit: lfsr <= {lfsr[2:0], lfsr[3]^lfsr[2]} (period 15).
  - 6-bit: lfsr <= {lfsr[4:0], lfsr[5]^lfsr[4]} (period 63).
  - Never reaches 0.
- Every rising edge:
  - player <= player_next.
  - If player_next == target (catch):
    - count <= (count==15) ? 15 : count+1
    - durum <= 1
    - target <= (x = lfsr_next upper half, y = lfsr_next lower half)
  - Otherwise: durum <= 0 and target holds.
- A relocated target may coincide with player_next. No special case: a catch occurs on the next edge only if the player's next position equals it.
- Latency: a move request is reflected in durum/count one edge later, with no extra pipeline.
- Outputs are driven directly from registers.

Optional Feature:
- Macro: CATCH_WRAP_EN.
- When defined, the grid is toroidal: moves past an edge wrap modulo 2^COORD_W (e.g. x=0 with left gives x=3).
- When undefined, clamp behaviour as above.
- No other behaviour changes.

Decomposition:
- Package catch_pkg holds:
  - direction bit index constants (DIR_UP=3, DIR_DOWN=2, DIR_LEFT=1, DIR_RIGHT=0)
  - LFSR tap table per COORD_W
  - CNT_MAX=15
  - packed struct type for a grid position (x,y)
- One sub-module, catch_lfsr: parameterised width, seed 1, with an enable input and outputs for both the current and next value.
- Movement and catch logic stay in catch.

Test Plan:
- Reset: rst=0 then 1 with yon=0000 for 5 cycles -> durum=0, yakalama_sayisi=0 throughout.
- Diagonal catch: after reset, yon=0101 for two edges -> player (1,1) then (2,2). Second edge gives durum=1, count=1; target becomes (1,0) from lfsr_next=0100. Third edge with yon=0000 -> durum=0, count=1.
- Edge clamp: after reset, yon=1010 for 3 edges -> player stays (0,0), no catch, count=0. With CATCH_WRAP_EN, the first edge moves the player to (3,3).
- Opposing bits: after reset, yon=1111 for 10 edges -> player stays (0,0), durum=0, count=0.
- Saturation: drive a scripted path producing 17 catches -> count reads 15 after the 15th catch and stays 15, while durum still pulses on each catch.
- Async reset mid-game: with count=3, pull rst low between clock edges -> count=0 and durum=0 immediately. After release, the first catch again lands at target (2,2).
